// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage. Owns the PC, runs a req/rdy fetch against
// instruction memory and presents Instruction/PC_add2 to decode. A one-entry
// hold buffer parks a fetch that completes while decode is stalled, so the
// memory never has to be asked twice for the same word.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] Instruction,
    output logic [15:0] PC_add2,
    output logic        if_valid,
    output logic        err
);

    typedef enum logic [2:0] {FETCH, SQUASH, HOLD, DRAIN, HALTED} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pend_addr;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc2;
    logic [15:0] pc_inc;
    logic        bad_tgt;

    // wraps modulo 2^16 by construction
    assign pc_inc  = pc + 16'd2;
    assign bad_tgt = redirect_addr[0];

    // pc is only updated when no request is outstanding, so the address is
    // stable for the whole life of a request
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH) || (state == SQUASH) || (state == DRAIN);

    // fetch control FSM with IF/ID, hold buffer and sticky error registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pend_addr   <= RESET_PC;
            hold_instr  <= NOP_INSTR;
            hold_pc2    <= 16'h0000;
            Instruction <= NOP_INSTR;
            PC_add2     <= 16'h0000;
            if_valid    <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        Instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                        if (bad_tgt) begin
                            err   <= 1'b1;
                            state <= imem_rdy ? HALTED : DRAIN;
                        end else if (imem_rdy) begin
                            pc <= redirect_addr;
                        end else begin
                            pend_addr <= redirect_addr;
                            state     <= SQUASH;
                        end
                    end else if (halt) begin
                        Instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                        state       <= imem_rdy ? HALTED : DRAIN;
                    end else if (imem_rdy) begin
                        pc <= pc_inc;
                        if (stall) begin
                            hold_instr <= imem_data;
                            hold_pc2   <= pc_inc;
                            state      <= HOLD;
                        end else begin
                            Instruction <= imem_data;
                            PC_add2     <= pc_inc;
                            if_valid    <= 1'b1;
                        end
                    end else if (!stall) begin
                        Instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                    end
                end
                SQUASH: begin
                    // IF/ID is already a bubble from the redirect that got us here
                    if (redirect) begin
                        if (bad_tgt) begin
                            err   <= 1'b1;
                            state <= imem_rdy ? HALTED : DRAIN;
                        end else if (imem_rdy) begin
                            pc    <= redirect_addr;
                            state <= FETCH;
                        end else begin
                            pend_addr <= redirect_addr;
                        end
                    end else if (halt) begin
                        state <= imem_rdy ? HALTED : DRAIN;
                    end else if (imem_rdy) begin
                        pc    <= pend_addr;
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    // nothing outstanding here, so a bad target halts at once
                    if (redirect) begin
                        Instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                        if (bad_tgt) begin
                            err   <= 1'b1;
                            state <= HALTED;
                        end else begin
                            pc    <= redirect_addr;
                            state <= FETCH;
                        end
                    end else if (halt) begin
                        Instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                        state       <= HALTED;
                    end else if (!stall) begin
                        Instruction <= hold_instr;
                        PC_add2     <= hold_pc2;
                        if_valid    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect && bad_tgt) begin
                        err <= 1'b1;
                    end
                    if (imem_rdy) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    Instruction <= NOP_INSTR;
                    if_valid    <= 1'b0;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench. A behavioural variable-latency
// memory answers fetches; each scenario queues the IF/ID entries decode is
// expected to consume, and a negedge monitor pops them as they are consumed.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] Instruction;
    logic [15:0] PC_add2;
    logic        if_valid;
    logic        err;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          wait_n = 0;
    int          cnt = 0;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    instruction_fetch #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
        .Instruction(Instruction), .PC_add2(PC_add2), .if_valid(if_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [7:0] h;
        h = a[8:1];
        return {8'h40 + h, h + 8'h01};
    endfunction

    // memory: answers after wait_n idle cycles of an asserted request
    assign imem_rdy  = imem_req && (cnt >= wait_n);
    assign imem_data = mem_word(imem_addr);
    always @(posedge clk) begin
        if (!rst || !imem_req || imem_rdy) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // decode consumes IF/ID at every edge where it is valid and not stalled;
    // also checks a pending request keeps its address until rdy
    always @(negedge clk) begin
        if (!rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_hold", imem_req, 1'b1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            prev_pend = imem_req && !imem_rdy;
            prev_addr = imem_addr;
            if (if_valid && !stall) begin
                if (sb.size() == 0) begin
                    chk("unexp_valid", if_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_instr", Instruction, e.instr);
                    chk("sb_pc2", PC_add2, e.pc2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(2 * i);
            sb.push_back('{mem_word(a), a + 16'd2});
        end
    endtask

    task automatic drain_sb(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    // returns just after the first negedge following reset release
    task automatic do_reset(input int w);
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        halt = 1'b0;
        wait_n = w;
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_instr", Instruction, 16'h0800);
        chk("rst_pc2", PC_add2, 16'h0000);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 16'h0000);
    endtask

    initial begin
        int reqs;
        int found;

        // zero-wait streaming
        do_reset(0);
        push_seq(16'h0000, 5);
        drain_sb("s1_stream");

        // two wait states
        do_reset(2);
        push_seq(16'h0000, 2);
        @(negedge clk);
        chk("s2_addr_c1", imem_addr, 16'h0000);
        chk("s2_valid_c1", if_valid, 1'b0);
        @(negedge clk);
        chk("s2_addr_c2", imem_addr, 16'h0000);
        chk("s2_valid_c2", if_valid, 1'b0);
        @(negedge clk);
        chk("s2_addr_c3", imem_addr, 16'h0002);
        chk("s2_instr_c3", Instruction, 16'h4001);
        drain_sb("s2_stream");

        // redirect while a request is waiting
        do_reset(2);
        push_seq(16'h0040, 2);
        redirect = 1'b1;
        redirect_addr = 16'h0040;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("s3_addr_c1", imem_addr, 16'h0000);
        @(negedge clk);
        chk("s3_addr_c2", imem_addr, 16'h0000);
        chk("s3_valid_c2", if_valid, 1'b0);
        @(negedge clk);
        chk("s3_addr_c3", imem_addr, 16'h0040);
        chk("s3_valid_c3", if_valid, 1'b0);
        drain_sb("s3_stream");

        // redirect with zero-wait memory
        do_reset(0);
        push_seq(16'h0100, 2);
        redirect = 1'b1;
        redirect_addr = 16'h0100;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("s3b_addr", imem_addr, 16'h0100);
        chk("s3b_valid", if_valid, 1'b0);
        drain_sb("s3b_stream");

        // stall while the fetch at 2 completes
        do_reset(0);
        push_seq(16'h0000, 3);
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("s4_instr_c1", Instruction, 16'h4001);
        tick();
        @(negedge clk);
        chk("s4_req_c2", imem_req, 1'b0);
        chk("s4_addr_c2", imem_addr, 16'h0004);
        tick();
        @(negedge clk);
        chk("s4_req_c3", imem_req, 1'b0);
        chk("s4_instr_c3", Instruction, 16'h4001);
        tick();
        stall = 1'b0;
        @(negedge clk);
        chk("s4_req_c4", imem_req, 1'b0);
        tick();
        @(negedge clk);
        chk("s4_req_c5", imem_req, 1'b1);
        chk("s4_addr_c5", imem_addr, 16'h0004);
        chk("s4_instr_c5", Instruction, 16'h4102);
        chk("s4_pc2_c5", PC_add2, 16'h0004);
        drain_sb("s4_stream");

        // halt with a pending request at PC 6
        do_reset(2);
        push_seq(16'h0000, 3);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (imem_addr == 16'h0006) begin
                found = 1;
                break;
            end
        end
        chk("s5_reach_pc6", imem_addr, 16'h0006);
        if (found == 1) begin
            halt = 1'b1;
            tick();
            halt = 1'b0;
            @(negedge clk);
            chk("s5_drain_req", imem_req, 1'b1);
            chk("s5_drain_addr", imem_addr, 16'h0006);
            chk("s5_drain_valid", if_valid, 1'b0);
            repeat (4) tick();
            reqs = 0;
            repeat (8) begin
                @(negedge clk);
                if (imem_req) reqs++;
            end
            chk("s5_halt_reqs", reqs, 0);
            chk("s5_halt_valid", if_valid, 1'b0);
            chk("s5_halt_instr", Instruction, 16'h0800);
            chk("s5_sb_empty", sb.size(), 0);
        end

        // misaligned redirect target
        do_reset(0);
        redirect = 1'b1;
        redirect_addr = 16'h0013;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("s6_err", err, 1'b1);
        chk("s6_req", imem_req, 1'b0);
        chk("s6_valid", if_valid, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        chk("s6_err_sticky", err, 1'b1);
        chk("s6_req_late", imem_req, 1'b0);

        // PC wrap from 16'hFFFE
        do_reset(0);
        push_seq(16'hFFFE, 2);
        redirect = 1'b1;
        redirect_addr = 16'hFFFE;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("s7_addr_fffe", imem_addr, 16'hFFFE);
        @(negedge clk);
        chk("s7_addr_wrap", imem_addr, 16'h0000);
        chk("s7_pc2_wrap", PC_add2, 16'h0000);
        drain_sb("s7_stream");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Pipeline stage upstream of instruction decode: holds the program counter, fetches 16-bit instructions from an instruction memory with a variable-latency req/rdy handshake, and drives the IF/ID outputs (`Instruction`, `PC_add2`) consumed by decode. It accepts redirects (branch, jump, JALR, siic, rti) resolved downstream, a stall from the hazard unit, and a halt. A one-entry hold buffer keeps a completed fetch when decode is stalled.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `NOP_INSTR`, default 16'h0800: instruction word injected as a bubble.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the clock edge).
- `stall`  in  1  decode cannot accept; hold IF/ID outputs.
- `redirect`  in  1  control-flow change resolved downstream.
- `redirect_addr`  in  16  target PC; valid with `redirect`.
- `halt`  in  1  HALT decoded; stop fetching.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  16  fetch address; stable while `imem_req`=1 until `imem_rdy`.
- `imem_rdy`  in  1  memory completes the request this cycle.
- `imem_data`  in  16  instruction; valid when `imem_rdy`=1.
- `Instruction`  out  16  IF/ID instruction.
- `PC_add2`  out  16  IF/ID address of fetched instruction + 2.
- `if_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `err`  out  1  sticky; misaligned redirect target.

## Operation
- Registers: `pc` (drives `imem_addr`), `pend_addr`, `hold_instr`, `hold_pc2`, IF/ID outputs, `err`, state.
- States: FETCH, SQUASH, HOLD, DRAIN, HALTED. `imem_req`=1 in FETCH, SQUASH, DRAIN; 0 in HOLD, HALTED.
- Priority each cycle: reset > redirect > halt > stall.
- A request, once issued, is never withdrawn: `imem_req` and `imem_addr` stay constant until `imem_rdy`.
- FETCH:
  - redirect with `imem_rdy`=1: discard data, `pc`<=`redirect_addr`, stay FETCH.
  - redirect with `imem_rdy`=0: `pend_addr`<=`redirect_addr`, go to SQUASH.
  - In both redirect cases, IF/ID <= NOP, `if_valid`<=0.
  - halt: `imem_rdy`=1 → HALTED (data discarded); else → DRAIN. IF/ID <= NOP.
  - `imem_rdy`=1, `stall`=0: `Instruction`<=`imem_data`, `PC_add2`<=`pc`+2, `if_valid`<=1, `pc`<=`pc`+2.
  - `imem_rdy`=1, `stall`=1: hold registers <= data and `pc`+2, `pc`<=`pc`+2, go to HOLD. IF/ID unchanged.
  - `imem_rdy`=0: if `stall`=0, IF/ID <= NOP, `if_valid`<=0; if `stall`=1, IF/ID unchanged.
- SQUASH: wait for `imem_rdy`, discard data, then `pc`<=`pend_addr` and go to FETCH. A new redirect overwrites `pend_addr`. Halt → DRAIN. IF/ID stays NOP.
- HOLD:
  - `stall`=0: IF/ID <= hold registers, `if_valid`<=1, go to FETCH.
  - redirect: discard hold, `pc`<=`redirect_addr`, IF/ID <= NOP, go to FETCH.
  - halt: go to HALTED.
- DRAIN: wait for `imem_rdy`, discard data, go to HALTED.
- HALTED: no requests; IF/ID = NOP, `if_valid`=0. Only reset exits this state.
- `redirect_addr[0]`=1: `err`<=1, IF/ID <= NOP, go to DRAIN if a request is outstanding, else HALTED.
- Arithmetic: `pc`+2 wraps modulo 2^16 (16'hFFFE+2 = 16'h0000).

## Timing
- Reset values: `pc`=`RESET_PC`, state FETCH, `Instruction`=`NOP_INSTR`, `PC_add2`=0, `if_valid`=0, `err`=0.
- First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Zero-wait memory (`imem_rdy` tied 1): one instruction per cycle. Data accepted at edge n appears on the IF/ID outputs after edge n.
- Redirect in cycle n with no outstanding wait: `imem_addr`=target in cycle n+1. With an outstanding request: target is presented the cycle after the old `imem_rdy`.
- Stall release from HOLD: held instruction appears after one edge; the next request issues in the following cycle.
- Reset asserted mid-request: state is abandoned; the memory handles the orphaned request.

## Test plan
- Reset, `imem_rdy`=1, memory[0]=16'h4001, memory[2]=16'h4102 → `Instruction`=16'h4001, `PC_add2`=2; next cycle 16'h4102 and 4; `if_valid`=1.
- Memory with 2 wait cycles → `imem_addr` held at 0 for 3 cycles; `if_valid`=0 during wait; then `Instruction`=mem[0].
- Redirect to 16'h0040 during a wait → request at 0 completes and is discarded; next `imem_addr`=16'h0040; IF/ID stays NOP until mem[0x40] arrives.
- `stall`=1 while the fetch at 2 completes → HOLD, `imem_req`=0. On `stall`=0 → `Instruction`=mem[2], `PC_add2`=4, then fetch at 4.
- `halt` at PC 6 with a pending request → drains, then `imem_req`=0 forever, `if_valid`=0; reset restarts at 0.
- Redirect to 16'h0013 → `err`=1, fetching stops. Separately, run PC from 16'hFFFE → `PC_add2`=0, next `imem_addr`=0.
